// File: rtl/sc_config_pkg.sv
// Shared definitions for the scan-converter configuration register bank.
// Provides the register word type, the read value returned for unmapped
// addresses, the CTRL register bit positions, and the byte-lane merge
// helper used by every writable register.
package sc_config_pkg;

   localparam int          REG_W        = 32;
   localparam logic [31:0] BAD_READ     = 32'hBAD0C0DE;
   localparam int          CTRL_ARM_BIT = 0;
   localparam int          CTRL_NOW_BIT = 1;

   typedef logic [REG_W-1:0] reg_word_t;

   // Take byte lane b from new_v where be[b] is set, otherwise keep old_v.
   function automatic reg_word_t be_merge(reg_word_t old_v, reg_word_t new_v, logic [3:0] be);
      reg_word_t r;
      for (int b = 0; b < 4; b++) begin
         r[8*b +: 8] = be[b] ? new_v[8*b +: 8] : old_v[8*b +: 8];
      end
      return r;
   endfunction

endpackage

// File: rtl/sc_config_regbank_if.sv
// Avalon-MM slave bus bundle for the configuration register bank.
//   address        word address (ADDR_W bits)
//   writedata      32-bit write data
//   byteenable     byte lanes for writes
//   write/read     access strobes, qualified by chipselect
//   readdata       registered read data (0 when readdatavalid is low)
//   readdatavalid  one-cycle pulse per read
//   waitrequest_n  slave never stalls (constant 1)
interface sc_config_regbank_if #(
   parameter int ADDR_W = 5
);
   import sc_config_pkg::*;

   logic [ADDR_W-1:0] address;
   reg_word_t         writedata;
   logic [3:0]        byteenable;
   logic              write;
   logic              read;
   logic              chipselect;
   reg_word_t         readdata;
   logic              readdatavalid;
   logic              waitrequest_n;

   modport master (
      output address, writedata, byteenable, write, read, chipselect,
      input  readdata, readdatavalid, waitrequest_n
   );

   modport slave (
      input  address, writedata, byteenable, write, read, chipselect,
      output readdata, readdatavalid, waitrequest_n
   );

endinterface

// File: rtl/sc_cfg_shadow_reg.sv
// One configuration word with an optional frame-synchronous shadow copy.
//   clk_i, rst_i  clock, asynchronous active-high reset
//   we, be, wdata byte-lane write into the pending copy
//   commit        copy pending -> active (shadowed words only)
//   pending_o     software-visible copy (what reads return)
//   active_o      copy driven to the video pipeline
// Unshadowed words have no separate active register: active follows pending.
module sc_cfg_shadow_reg
   import sc_config_pkg::*;
#(
   parameter reg_word_t RESET  = '0,
   parameter bit        SHADOW = 1'b0
) (
   input  logic      clk_i,
   input  logic      rst_i,
   input  logic      we,
   input  logic [3:0] be,
   input  reg_word_t wdata,
   input  logic      commit,
   output reg_word_t pending_o,
   output reg_word_t active_o
);

   reg_word_t pend_q, pend_d;

   always_comb begin
      pend_d = pend_q;
      if (we) pend_d = be_merge(pend_q, wdata, be);
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) pend_q <= RESET;
      else       pend_q <= pend_d;
   end

   assign pending_o = pend_q;

   generate
      if (SHADOW) begin : g_shadow
         reg_word_t act_q;
         // Commit samples the pending value from before this edge, so a write
         // landing on the same edge stays pending for the next commit.
         always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i)       act_q <= RESET;
            else if (commit) act_q <= pend_q;
         end
         assign active_o = act_q;
      end else begin : g_direct
         logic unused_commit;
         assign unused_commit = commit;
         assign active_o      = pend_q;
      end
   endgenerate

endmodule

// File: rtl/sc_config_regbank.sv
// Avalon-MM configuration/status register bank for the scan converter.
// Ports:
//   clk_i, rst_i  clock, asynchronous active-high reset
//   avalon_s      Avalon-MM slave (sc_config_regbank_if.slave)
//   status_i      N_STATUS read-only status words, sampled in the read cycle
//   vsync_i       frame sync level; its rising edge commits an armed update
//   event_i       one-cycle event pulses captured into sticky W1C bits
//   config_o      active configuration words
//   irq_o         registered OR of enabled sticky events
// Map: STATUS, CONFIG, then EVENT (W1C), IRQ_EN, CTRL (ARM bit0, NOW bit1).
module sc_config_regbank
   import sc_config_pkg::*;
#(
   parameter int                      N_STATUS    = 4,
   parameter int                      N_CONFIG    = 13,
   parameter int                      ADDR_W      = 5,
   parameter logic [32*N_CONFIG-1:0]  CFG_RESET   = '0,
   parameter logic [N_CONFIG-1:0]     SHADOW_MASK = '0,
   parameter int                      N_EVENT     = 8
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   sc_config_regbank_if.slave       avalon_s,
   input  logic [32*N_STATUS-1:0]   status_i,
   input  logic                     vsync_i,
   input  logic [N_EVENT-1:0]       event_i,
   output logic [32*N_CONFIG-1:0]   config_o,
   output logic                     irq_o
);

   localparam int        A_CFG   = N_STATUS;
   localparam int        A_EVENT = N_STATUS + N_CONFIG;
   localparam int        A_IRQEN = A_EVENT + 1;
   localparam int        A_CTRL  = A_EVENT + 2;
   localparam reg_word_t EV_MASK = reg_word_t'((64'h1 << N_EVENT) - 64'h1);

   logic [ADDR_W-1:0] addr;
   reg_word_t         wdata;
   logic [3:0]        be;
   logic              wr_acc, rd_acc;
   logic              wr_event, wr_irqen, wr_ctrl;

   assign addr  = avalon_s.address;
   assign wdata = avalon_s.writedata;
   assign be    = avalon_s.byteenable;

   assign wr_acc   = avalon_s.chipselect & avalon_s.write;
   assign rd_acc   = avalon_s.chipselect & avalon_s.read;
   assign wr_event = wr_acc && (addr == ADDR_W'(A_EVENT));
   assign wr_irqen = wr_acc && (addr == ADDR_W'(A_IRQEN));
   assign wr_ctrl  = wr_acc && (addr == ADDR_W'(A_CTRL));

   // Commit controller
   logic vsync_q, armed_q, armed_d;
   logic vsync_rise, arm_wr, now_wr, commit;

   assign vsync_rise = vsync_i & ~vsync_q;
   assign arm_wr     = wr_ctrl && be[0] && wdata[CTRL_ARM_BIT];
   assign now_wr     = wr_ctrl && be[0] && wdata[CTRL_NOW_BIT];
   // Only an already-armed request can commit on this rise; an ARM write in
   // the same cycle waits for the following rise.
   assign commit     = (armed_q & vsync_rise) | now_wr;

   always_comb begin
      armed_d = armed_q;
      if (commit) armed_d = 1'b0;
      if (arm_wr) armed_d = 1'b1;
   end

   // Config words
   reg_word_t cfg_pend [N_CONFIG];

   generate
      for (genvar k = 0; k < N_CONFIG; k++) begin : g_cfg
         logic we_k;
         assign we_k = wr_acc && (addr == ADDR_W'(A_CFG + k));
         sc_cfg_shadow_reg #(
            .RESET  (CFG_RESET[32*k +: 32]),
            .SHADOW (SHADOW_MASK[k])
         ) u_reg (
            .clk_i     (clk_i),
            .rst_i     (rst_i),
            .we        (we_k),
            .be        (be),
            .wdata     (wdata),
            .commit    (commit),
            .pending_o (cfg_pend[k]),
            .active_o  (config_o[32*k +: 32])
         );
      end
   endgenerate

   // Sticky events and interrupt; bits at N_EVENT and above are held at 0.
   reg_word_t sticky_q, sticky_d, irq_en_q, irq_en_d, ev_ext, ev_clr;
   logic      irq_q, irq_d;

   always_comb begin
      ev_ext               = '0;
      ev_ext[N_EVENT-1:0]  = event_i;
      ev_clr               = '0;
      if (wr_event) ev_clr = be_merge('0, wdata, be);
      // Set wins over a coincident clear.
      sticky_d = ((sticky_q & ~ev_clr) | ev_ext) & EV_MASK;
      irq_en_d = irq_en_q;
      if (wr_irqen) irq_en_d = be_merge(irq_en_q, wdata, be) & EV_MASK;
      irq_d    = |(sticky_q & irq_en_q);
   end

   // Read mux
   reg_word_t rmux, rdata_q, rdata_d;
   logic      rvld_q, rvld_d;

   always_comb begin
      rmux = BAD_READ;
      for (int i = 0; i < N_STATUS; i++) begin
         if (addr == ADDR_W'(i)) rmux = status_i[32*i +: 32];
      end
      for (int k = 0; k < N_CONFIG; k++) begin
         if (addr == ADDR_W'(A_CFG + k)) rmux = cfg_pend[k];
      end
      if (addr == ADDR_W'(A_EVENT)) rmux = sticky_q;
      if (addr == ADDR_W'(A_IRQEN)) rmux = irq_en_q;
      if (addr == ADDR_W'(A_CTRL)) begin
         rmux               = '0;
         rmux[CTRL_ARM_BIT] = armed_q;
      end
      rdata_d = rd_acc ? rmux : '0;
      rvld_d  = rd_acc;
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         vsync_q  <= 1'b0;
         armed_q  <= 1'b0;
         sticky_q <= '0;
         irq_en_q <= '0;
         irq_q    <= 1'b0;
         rdata_q  <= '0;
         rvld_q   <= 1'b0;
      end else begin
         vsync_q  <= vsync_i;
         armed_q  <= armed_d;
         sticky_q <= sticky_d;
         irq_en_q <= irq_en_d;
         irq_q    <= irq_d;
         rdata_q  <= rdata_d;
         rvld_q   <= rvld_d;
      end
   end

   assign avalon_s.readdata      = rdata_q;
   assign avalon_s.readdatavalid = rvld_q;
   assign avalon_s.waitrequest_n = 1'b1;
   assign irq_o                  = irq_q;

endmodule

// File: tb/tb_sc_config_regbank.sv
module tb_sc_config_regbank;

   localparam int N_STATUS = 4;
   localparam int N_CONFIG = 13;
   localparam int ADDR_W   = 5;
   localparam int N_EVENT  = 8;
   localparam logic [32*N_CONFIG-1:0] CFG_RST = {32'h0000_0100, {12{32'h0}}};
   localparam logic [N_CONFIG-1:0]    SH_MASK = 13'b0_0000_0000_1000;

   localparam logic [4:0] A_EVENT = 5'd17;
   localparam logic [4:0] A_IRQEN = 5'd18;
   localparam logic [4:0] A_CTRL  = 5'd19;

   logic                     clk = 1'b0;
   logic                     rst;
   logic [32*N_STATUS-1:0]   status;
   logic                     vsync;
   logic [N_EVENT-1:0]       event_in;
   logic [32*N_CONFIG-1:0]   cfg;
   logic                     irq;

   int n_chk  = 0;
   int n_fail = 0;

   logic [31:0] rd_d;
   logic        rd_v;

   sc_config_regbank_if #(.ADDR_W(ADDR_W)) bus ();

   sc_config_regbank #(
      .N_STATUS    (N_STATUS),
      .N_CONFIG    (N_CONFIG),
      .ADDR_W      (ADDR_W),
      .CFG_RESET   (CFG_RST),
      .SHADOW_MASK (SH_MASK),
      .N_EVENT     (N_EVENT)
   ) dut (
      .clk_i    (clk),
      .rst_i    (rst),
      .avalon_s (bus.slave),
      .status_i (status),
      .vsync_i  (vsync),
      .event_i  (event_in),
      .config_o (cfg),
      .irq_o    (irq)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 32'h%08h, expected 32'h%08h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] cfg_w(input int k);
      return cfg[32*k +: 32];
   endfunction

   // Called at a falling edge; spans one rising edge and returns at the next falling edge.
   task automatic bus_wr(input logic [4:0] a, input logic [31:0] d, input logic [3:0] b);
      bus.chipselect = 1'b1;
      bus.write      = 1'b1;
      bus.address    = a;
      bus.writedata  = d;
      bus.byteenable = b;
      @(negedge clk);
      bus.chipselect = 1'b0;
      bus.write      = 1'b0;
      bus.byteenable = 4'h0;
   endtask

   task automatic bus_rd(input logic [4:0] a, output logic [31:0] d, output logic v);
      bus.chipselect = 1'b1;
      bus.read       = 1'b1;
      bus.address    = a;
      @(negedge clk);
      d = bus.readdata;
      v = bus.readdatavalid;
      bus.chipselect = 1'b0;
      bus.read       = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      rst            = 1'b1;
      vsync          = 1'b0;
      event_in       = '0;
      status         = {32'hDEAD0003, 32'hDEAD0002, 32'hDEAD0001, 32'hDEAD0000};
      bus.chipselect = 1'b0;
      bus.read       = 1'b0;
      bus.write      = 1'b0;
      bus.address    = '0;
      bus.writedata  = '0;
      bus.byteenable = 4'h0;
      repeat (3) @(negedge clk);

      chk("rst_rdvalid", 32'(bus.readdatavalid), 32'd0);
      chk("rst_rdata",   bus.readdata, 32'd0);
      chk("rst_irq",     32'(irq), 32'd0);
      chk("rst_cfg12",   cfg_w(12), 32'h0000_0100);
      chk("rst_cfg0",    cfg_w(0), 32'd0);
      rst = 1'b0;
      @(negedge clk);
      chk("waitreq_n",   32'(bus.waitrequest_n), 32'd1);

      // Reset value readback with one-cycle latency
      bus_rd(5'd16, rd_d, rd_v);
      chk("t1_vld",  32'(rd_v), 32'd1);
      chk("t1_data", rd_d, 32'h0000_0100);
      @(negedge clk);
      chk("t1_vld_drop",  32'(bus.readdatavalid), 32'd0);
      chk("t1_data_zero", bus.readdata, 32'd0);

      // Unshadowed byte-lane write
      bus_wr(5'd4, 32'hAABBCCDD, 4'b0101);
      chk("t2_cfg0", cfg_w(0), 32'h00BB00DD);
      bus_rd(5'd4, rd_d, rd_v);
      chk("t2_read", rd_d, 32'h00BB00DD);

      // Shadowed word committed on vsync rise after ARM
      bus_wr(5'd7, 32'h12345678, 4'hF);
      chk("t3_cfg3_hold0", cfg_w(3), 32'd0);
      bus_wr(A_CTRL, 32'h1, 4'hF);
      bus_rd(A_CTRL, rd_d, rd_v);
      chk("t3_ctrl_armed", rd_d, 32'd1);
      chk("t3_cfg3_hold1", cfg_w(3), 32'd0);
      vsync = 1'b1;
      @(negedge clk);
      chk("t3_cfg3_commit", cfg_w(3), 32'h12345678);
      vsync = 1'b0;
      bus_rd(A_CTRL, rd_d, rd_v);
      chk("t3_ctrl_clear", rd_d, 32'd0);
      bus_rd(5'd7, rd_d, rd_v);
      chk("t3_pend", rd_d, 32'h12345678);

      // Write coincident with commit, then NOW commit
      bus_wr(5'd7, 32'h5, 4'hF);
      bus_wr(A_CTRL, 32'h1, 4'hF);
      vsync = 1'b1;
      bus_wr(5'd7, 32'h1, 4'hF);
      vsync = 1'b0;
      chk("t4_active_old", cfg_w(3), 32'h5);
      bus_rd(5'd7, rd_d, rd_v);
      chk("t4_pend_new", rd_d, 32'h1);
      bus_rd(A_CTRL, rd_d, rd_v);
      chk("t4_armed_cleared", rd_d, 32'd0);
      bus_wr(A_CTRL, 32'h2, 4'hF);
      chk("t4_now_commit", cfg_w(3), 32'h1);
      bus_rd(A_CTRL, rd_d, rd_v);
      chk("t4_now_reads0", rd_d, 32'd0);

      // ARM coincident with a vsync rise waits for the next rise
      bus_wr(5'd7, 32'h7, 4'hF);
      vsync = 1'b1;
      bus_wr(A_CTRL, 32'h1, 4'hF);
      vsync = 1'b0;
      chk("t4_arm_rise_nocommit", cfg_w(3), 32'h1);
      bus_rd(A_CTRL, rd_d, rd_v);
      chk("t4_arm_rise_armed", rd_d, 32'd1);
      vsync = 1'b1;
      @(negedge clk);
      vsync = 1'b0;
      chk("t4_next_rise_commit", cfg_w(3), 32'h7);
      chk("t4_cfg0_untouched", cfg_w(0), 32'h00BB00DD);
      bus_rd(A_CTRL, rd_d, rd_v);
      chk("t4_ctrl_after", rd_d, 32'd0);

      // IRQ enable width, events and W1C
      bus_wr(A_IRQEN, 32'hFFFFFFFF, 4'hF);
      bus_rd(A_IRQEN, rd_d, rd_v);
      chk("t5_irqen_width", rd_d, 32'h0000_00FF);
      bus_wr(A_IRQEN, 32'h4, 4'hF);
      bus_rd(A_IRQEN, rd_d, rd_v);
      chk("t5_irqen", rd_d, 32'h4);
      event_in = 8'h04;
      @(negedge clk);
      event_in = '0;
      chk("t5_irq_1cyc", 32'(irq), 32'd0);
      @(negedge clk);
      chk("t5_irq_2cyc", 32'(irq), 32'd1);
      bus_rd(A_EVENT, rd_d, rd_v);
      chk("t5_event", rd_d, 32'h4);
      event_in = 8'h04;
      bus_wr(A_EVENT, 32'h4, 4'hF);
      event_in = '0;
      bus_rd(A_EVENT, rd_d, rd_v);
      chk("t5_set_wins", rd_d, 32'h4);
      chk("t5_irq_held", 32'(irq), 32'd1);
      bus_wr(A_EVENT, 32'h4, 4'hF);
      @(negedge clk);
      chk("t5_irq_cleared", 32'(irq), 32'd0);
      event_in = 8'h80;
      @(negedge clk);
      event_in = '0;
      repeat (2) @(negedge clk);
      chk("t5_irq_masked", 32'(irq), 32'd0);
      bus_wr(A_EVENT, 32'hFF, 4'b0000);
      bus_rd(A_EVENT, rd_d, rd_v);
      chk("t5_w1c_no_lanes", rd_d, 32'h80);

      // Unmapped / read-only
      bus_rd(5'd25, rd_d, rd_v);
      chk("t6_unmapped", rd_d, 32'hBAD0C0DE);
      chk("t6_unmapped_vld", 32'(rd_v), 32'd1);
      bus_wr(5'd2, 32'h0, 4'hF);
      bus_rd(5'd2, rd_d, rd_v);
      chk("t6_status_ro", rd_d, 32'hDEAD0002);

      // Reset during a read
      event_in = 8'h04;
      @(negedge clk);
      event_in = '0;
      repeat (2) @(negedge clk);
      chk("t6_irq_before_rst", 32'(irq), 32'd1);
      bus.chipselect = 1'b1;
      bus.read       = 1'b1;
      bus.address    = 5'd4;
      #2 rst = 1'b1;
      @(negedge clk);
      bus.chipselect = 1'b0;
      bus.read       = 1'b0;
      chk("t6_rst_vld",   32'(bus.readdatavalid), 32'd0);
      chk("t6_rst_rdata", bus.readdata, 32'd0);
      chk("t6_rst_irq",   32'(irq), 32'd0);
      chk("t6_rst_cfg0",  cfg_w(0), 32'd0);
      chk("t6_rst_cfg3",  cfg_w(3), 32'd0);
      chk("t6_rst_cfg12", cfg_w(12), 32'h0000_0100);
      rst = 1'b0;
      @(negedge clk);
      chk("t6_post_rst_vld", 32'(bus.readdatavalid), 32'd0);
      bus_rd(A_EVENT, rd_d, rd_v);
      chk("t6_post_event", rd_d, 32'd0);
      bus_rd(A_IRQEN, rd_d, rd_v);
      chk("t6_post_irqen", rd_d, 32'd0);
      bus_rd(5'd7, rd_d, rd_v);
      chk("t6_post_pend3", rd_d, 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
